fp_expand_acc: RTL

FP_EXPAND_ACC -- requirements
Module: fp_expand_acc

---
 rtl/fp_expand_acc_pkg.sv | 8 +
 rtl/fp_decode.sv | 15 +
 rtl/fp_expand_acc.sv | 79 +++++++
 3 files changed

// File: rtl/fp_expand_acc_pkg.sv
// fp_expand_acc_pkg: widths and limits shared with the floating-point converter.
package fp_expand_acc_pkg;
  localparam int EXP_W = 3;
  localparam int SIG_W = 4;
  localparam int VAL_W = 12;
  localparam int MAG_W = 11;
  localparam int MAG_MAX = 1920;
endpackage

// File: rtl/fp_decode.sv
// fp_decode: combinational sign/shift expansion of a tiny float into a signed integer.
module fp_decode
  import fp_expand_acc_pkg::*;
(
  input  logic             s_i,
  input  logic [EXP_W-1:0] e_i,
  input  logic [SIG_W-1:0] f_i,
  output logic [VAL_W-1:0] val_o
);
  logic [MAG_W-1:0] mag;
  always_comb begin
    mag = MAG_W'(f_i) << e_i;
    val_o = s_i ? -{1'b0, mag} : {1'b0, mag};
  end
endmodule

// File: rtl/fp_expand_acc.sv
// fp_expand_acc: decodes tiny floats, then accumulates WINDOW samples into a
// saturating signed window sum.
module fp_expand_acc
  import fp_expand_acc_pkg::*;
#(
  parameter int WINDOW = 8,
  parameter int ACC_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             in_s,
  input  logic [EXP_W-1:0] in_e,
  input  logic [SIG_W-1:0] in_f,
  output logic [VAL_W-1:0] val_out,
  output logic             val_valid,
  output logic [ACC_W-1:0] sum_out,
  output logic             sum_valid,
  output logic             sum_sat,
  output logic [7:0]       cnt
);
  logic [VAL_W-1:0] dec, val_q, val_d;
  logic             vv_q, vv_d;
  logic [ACC_W-1:0] acc_q, acc_d, sum_q, sum_d, sum_c;
  logic [7:0]       cnt_q, cnt_d;
  logic             sat_q, sat_d, ss_q, ss_d, sv_q, sv_d;
  logic [ACC_W:0]   sum_w;
  logic             ovf, take, done;
  fp_decode u_dec (
    .s_i  (in_s),
    .e_i  (in_e),
    .f_i  (in_f),
    .val_o(dec)
  );
  // One extra bit of headroom makes overflow visible as a mismatch of the top two bits.
  always_comb begin
    sum_w = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-VAL_W){val_q[VAL_W-1]}}, val_q};
    ovf = sum_w[ACC_W] ^ sum_w[ACC_W-1];
    sum_c = ovf ? {sum_w[ACC_W], {(ACC_W-1){~sum_w[ACC_W]}}} : sum_w[ACC_W-1:0];
    take = vv_q && !clr;
    done = take && (cnt_q == 8'(WINDOW - 1));
    vv_d = in_valid && !clr;
    val_d = vv_d ? dec : val_q;
    acc_d = (clr || done) ? '0 : take ? sum_c : acc_q;
    cnt_d = (clr || done) ? '0 : take ? cnt_q + 8'd1 : cnt_q;
    sat_d = (clr || done) ? 1'b0 : sat_q | (take & ovf);
    sum_d = done ? sum_c : sum_q;
    ss_d = done ? (sat_q | ovf) : ss_q;
    sv_d = done;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= '0;
      vv_q  <= 1'b0;
      acc_q <= '0;
      cnt_q <= '0;
      sat_q <= 1'b0;
      sum_q <= '0;
      ss_q  <= 1'b0;
      sv_q  <= 1'b0;
    end else begin
      val_q <= val_d;
      vv_q  <= vv_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      sat_q <= sat_d;
      sum_q <= sum_d;
      ss_q  <= ss_d;
      sv_q  <= sv_d;
    end
  end
  assign val_out   = val_q;
  assign val_valid = vv_q;
  assign sum_out   = sum_q;
  assign sum_valid = sv_q;
  assign sum_sat   = ss_q;
  assign cnt       = cnt_q;
endmodule
